// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants for the board clock divider.
// Half-period values are derived from the 100 MHz board clock.
package clk_div_pkg;

  localparam int unsigned BOARD_HZ = 100_000_000;
  localparam int unsigned TICK_HZ_DEF = 10_000;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned DEFAULT_HALF_DEF =
    BOARD_HZ / (2 * TICK_HZ_DEF) - 1;

endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one divider channel with glitch-free divisor reload.
// A new divisor is only switched in while cnt returns to zero.
module clk_div_channel #(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = 4999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             load,
  input  logic [CNT_W-1:0] div_half,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_act;
  logic [CNT_W-1:0] half_pend;
  logic             term;
  logic             apply;

  always_comb begin
    term  = (cnt == half_act);
    apply = pending && (restart || (en && term));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      half_act <= RST_HALF;
    end else begin
      tick <= 1'b0;
      if (restart) begin
        cnt     <= '0;
        clk_out <= 1'b0;
      end else if (en) begin
        if (term) begin
          cnt     <= '0;
          clk_out <= ~clk_out;
          tick    <= ~clk_out;
        end else begin
          cnt <= cnt + ONE;
        end
      end
      if (apply) half_act <= half_pend;
    end
  end

  // a load on the applying edge wins, so it stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= 1'b0;
      half_pend <= RST_HALF;
    end else if (load) begin
      pending   <= 1'b1;
      half_pend <= div_half;
    end else if (apply) begin
      pending <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// clk_div_gen: NUM_CH independent clock dividers with tick outputs.
// Channels share only clk, rst, en and restart.
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    restart,
  input  logic [NUM_CH*CNT_W-1:0] div_half,
  input  logic [NUM_CH-1:0]       load,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .restart  (restart),
      .load     (load[i]),
      .div_half (div_half[i*CNT_W +: CNT_W]),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: scoreboard plus directed checks for clk_div_gen.
// Two channels, 16-bit counters, reset half-period 4999.
module tb_clk_div_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        restart;
  logic [31:0] div_half;
  logic [1:0]  load;
  logic [1:0]  clk_out;
  logic [1:0]  tick;
  logic [1:0]  pending;

  always #5 clk = ~clk;

  clk_div_gen #(
    .NUM_CH       (2),
    .CNT_W        (16),
    .DEFAULT_HALF (4999)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .restart  (restart),
    .div_half (div_half),
    .load     (load),
    .clk_out  (clk_out),
    .tick     (tick),
    .pending  (pending)
  );

  typedef struct packed {
    logic [1:0] out;
    logic [1:0] tck;
    logic [1:0] pnd;
  } exp_t;

  typedef struct {
    logic        en;
    logic        restart;
    logic [1:0]  load;
    logic [15:0] d0;
    logic [15:0] d1;
    int          n;
    logic [1:0]  pend;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc_no = 0;

  logic [15:0] m_cnt[2];
  logic [15:0] m_act[2];
  logic [15:0] m_hp[2];
  logic        m_out[2];
  logic        m_tick[2];
  logic        m_pend[2];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_act[i] = 16'd4999; m_hp[i] = 16'd4999;
      m_out[i] = 0; m_tick[i] = 0; m_pend[i] = 0;
    end
  endtask

  // next-state model of one clk edge, from the current inputs
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic ap;
      ap = 1'b0;
      m_tick[i] = 1'b0;
      if (restart) begin
        ap = m_pend[i];
        m_cnt[i] = 0;
        m_out[i] = 0;
      end else if (en) begin
        if (m_cnt[i] == m_act[i]) begin
          ap = m_pend[i];
          m_cnt[i] = 0;
          m_tick[i] = !m_out[i];
          m_out[i] = !m_out[i];
        end else begin
          m_cnt[i] = m_cnt[i] + 16'd1;
        end
      end
      if (ap) m_act[i] = m_hp[i];
      if (load[i]) begin
        m_hp[i] = div_half[i*16 +: 16];
        m_pend[i] = 1'b1;
      end else if (ap) begin
        m_pend[i] = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    exp_t e;
    exp_t g;
    model_step();
    e.out = {m_out[1], m_out[0]};
    e.tck = {m_tick[1], m_tick[0]};
    e.pnd = {m_pend[1], m_pend[0]};
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cyc_no++;
    e = sbq.pop_front();
    g = {clk_out, tick, pending};
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL sb cyc=%0d got=%b exp=%b", cyc_no, g, e);
    end
  endtask

  task automatic run_until_tick(input int ch, input int max,
                                output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!tick[ch] && n < max);
    if (!tick[ch]) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    vec_t tbl[6];
    int   n;
    int   hi;
    logic [15:0] m0;
    logic [15:0] m1;

    tbl[0] = '{1'b0, 1'b0, 2'b01, 16'd2, 16'd0, 1, 2'b01};
    tbl[1] = '{1'b0, 1'b0, 2'b00, 16'd0, 16'd0, 5, 2'b01};
    tbl[2] = '{1'b1, 1'b1, 2'b10, 16'd0, 16'd6, 1, 2'b10};
    tbl[3] = '{1'b1, 1'b0, 2'b10, 16'd0, 16'd2, 1, 2'b10};
    tbl[4] = '{1'b1, 1'b0, 2'b00, 16'd0, 16'd0, 3, 2'b00};
    tbl[5] = '{1'b1, 1'b0, 2'b00, 16'd0, 16'd0, 20, 2'b00};

    rst = 1'b1; en = 1'b0; restart = 1'b0;
    load = 2'b00; div_half = '0;
    #12;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    en = 1'b1;

    // default divisor: first rise, then full period and duty
    run_until_tick(0, 6000, n);
    chk("t1_first_rise", 32'(n), 32'd5000);
    chk("t1_both_tick", 32'(tick), 32'd3);
    n = 0; hi = 0;
    do begin
      cyc();
      n++;
      if (clk_out[0]) hi++;
    end while (!tick[0] && n < 12000);
    chk("t1_period", 32'(n), 32'd10000);
    chk("t1_high", 32'(hi), 32'd5000);

    // ch0 -> half 0, applied at end of current half-period
    load = 2'b01; div_half = {16'd0, 16'd0};
    cyc();
    load = 2'b00;
    chk("t2_pending", 32'(pending), 32'd1);
    n = 0;
    while (pending[0] && n < 6000) begin
      cyc();
      n++;
    end
    chk("t2_applied", 32'(n), 32'd4999);
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (tick[0]) hi++;
    end
    chk("t2_div2_ticks", 32'(hi), 32'd5);

    // ch0 half 4 via restart, then reload 9 at cnt=3
    load = 2'b01; div_half = {16'd0, 16'd4};
    cyc();
    load = 2'b00; restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("t3_restart_out", 32'(clk_out), 32'd0);
    run(3);
    load = 2'b01; div_half = {16'd0, 16'd9};
    cyc();
    load = 2'b00;
    chk("t3_cnt4", {30'd0, clk_out[0], pending[0]}, 32'd1);
    cyc();
    chk("t3_switch", {29'd0, clk_out[0], tick[0], pending[0]}, 32'd6);
    run(9);
    chk("t3_hi10", 32'(clk_out[0]), 32'd1);
    load = 2'b01; div_half = {16'd0, 16'd4};
    cyc();
    load = 2'b00;
    chk("t3_late_load", {30'd0, clk_out[0], pending[0]}, 32'd1);
    run(9);
    chk("t3_still_pend", {30'd0, clk_out[0], pending[0]}, 32'd1);
    cyc();
    chk("t3_late_apply", {29'd0, clk_out[0], tick[0], pending[0]}, 32'd6);

    // en=0 for 7 cycles stretches one period by 7
    run(3);
    en = 1'b0;
    hi = 0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      if (tick != 2'b00) hi++;
    end
    en = 1'b1;
    chk("t4_no_tick", 32'(hi), 32'd0);
    run_until_tick(0, 40, n);
    chk("t4_period", 32'(n + 10), 32'd17);

    // ch0 half 1, ch1 half 3, restart aligned
    load = 2'b11; div_half = {16'd3, 16'd1};
    cyc();
    load = 2'b00; restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("t5_restart_out", 32'(clk_out), 32'd0);
    m0 = '0; m1 = '0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      m0[k] = tick[0];
      m1[k] = tick[1];
    end
    chk("t5_ch0_ticks", 32'(m0), 32'h2222);
    chk("t5_ch1_ticks", 32'(m1), 32'h0808);

    // table: loads under en=0, restart and overwrite
    foreach (tbl[v]) begin
      en = tbl[v].en;
      restart = tbl[v].restart;
      load = tbl[v].load;
      div_half = {tbl[v].d1, tbl[v].d0};
      cyc();
      load = 2'b00; restart = 1'b0;
      run(tbl[v].n - 1);
      chk($sformatf("vec%0d_pend", v), 32'(pending),
          32'(tbl[v].pend));
    end

    // async reset while clk_out[0] is high
    n = 0;
    while (!clk_out[0] && n < 20) begin
      cyc();
      n++;
    end
    chk("t6_high", 32'(clk_out[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("t6_async_out", 32'(clk_out), 32'd0);
    chk("t6_async_pend", 32'(pending), 32'd0);
    #1 rst = 1'b0;
    model_reset();
    run_until_tick(0, 6000, n);
    chk("t6_default_half", 32'(n), 32'd5000);
    chk("t6_both_tick", 32'(tick), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
